icache_assoc_line: RTL

//  Parametrised set-associative instruction cache with multi-word lines, between the IFetcher and MemCtrl.

---
 rtl/icache_assoc_line_pkg.sv | 20 ++
 rtl/icache_assoc_line_way.sv | 58 +++++
 rtl/icache_assoc_line.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/icache_assoc_line_pkg.sv
// Shared defaults, FSM encoding and sizing helper for the set-associative icache.
// Pure declarations; no timing and no flow control.
package icache_assoc_line_pkg;

    localparam int ICACHE_WAYS       = 2;
    localparam int ICACHE_SETS       = 64;
    localparam int ICACHE_LINE_WORDS = 4;
    localparam int ICACHE_ADDR_W     = 18;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } state_e;

    // Pointer width that stays legal for a single-entry index space.
    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/icache_assoc_line_way.sv
// One cache way: word data, per-set tag and valid. Reads are combinational;
// writes and valid updates land at the edge. No flow control; the caller gates every strobe.
module icache_assoc_line_way
    import icache_assoc_line_pkg::*;
#(
    parameter int SETS       = ICACHE_SETS,
    parameter int LINE_WORDS = ICACHE_LINE_WORDS,
    parameter int TAG_W      = 8,
    localparam int SET_W     = $clog2(SETS),
    localparam int OFF_W     = $clog2(LINE_WORDS)
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [SET_W-1:0]  rd_set_i,
    input  logic [OFF_W-1:0]  rd_off_i,
    input  logic [TAG_W-1:0]  rd_tag_i,
    output logic [31:0]       rd_word_o,
    output logic              rd_match_o,
    input  logic              wr_en_i,
    input  logic [SET_W-1:0]  wr_set_i,
    input  logic [OFF_W-1:0]  wr_off_i,
    input  logic [31:0]       wr_word_i,
    input  logic              tag_wr_i,
    input  logic [TAG_W-1:0]  tag_i,
    input  logic              inv_i,
    input  logic              flush_i
);

    logic [SETS-1:0]  valid_q;
    logic [TAG_W-1:0] tag_q  [SETS];
    logic [31:0]      data_q [SETS*LINE_WORDS];

    assign rd_word_o  = data_q[{rd_set_i, rd_off_i}];
    assign rd_match_o = valid_q[rd_set_i] && (tag_q[rd_set_i] == rd_tag_i);

    // Flush wins over install so an aborted refill can never leave a valid line.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            valid_q <= '0;
        end else if (flush_i) begin
            valid_q <= '0;
        end else if (tag_wr_i) begin
            valid_q[wr_set_i] <= 1'b1;
        end else if (inv_i) begin
            valid_q[wr_set_i] <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (tag_wr_i) begin
            tag_q[wr_set_i] <= tag_i;
        end
        if (wr_en_i) begin
            data_q[{wr_set_i, wr_off_i}] <= wr_word_i;
        end
    end

endmodule

// File: rtl/icache_assoc_line.sv
// Set-associative icache: 0-cycle hits, line refill as LINE_WORDS sequential word requests with
// critical-word forwarding; need_mem held until mem_ins_ready, rdy_in=0 freezes all state.
module icache_assoc_line
    import icache_assoc_line_pkg::*;
#(
    parameter int WAYS       = ICACHE_WAYS,
    parameter int SETS       = ICACHE_SETS,
    parameter int LINE_WORDS = ICACHE_LINE_WORDS,
    parameter int ADDR_W     = ICACHE_ADDR_W
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    output logic        need_mem,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_ins,
    input  logic        mem_ins_ready,
    input  logic        fetch_able,
    input  logic [31:0] input_pc,
    input  logic        flush,
    output logic        hit,
    output logic [31:0] hit_ins,
    output logic [31:0] ins_pc,
    output logic        busy
);

    localparam int OFF_W   = $clog2(LINE_WORDS);
    localparam int SET_W   = $clog2(SETS);
    localparam int TAG_W   = ADDR_W - SET_W - OFF_W - 2;
    localparam int WAY_W   = ptr_w(WAYS);
    localparam int SET_LSB = OFF_W + 2;
    localparam int TAG_LSB = SET_LSB + SET_W;

    state_e            state_q, state_d;
    logic [OFF_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [31:0]       mem_addr_q, mem_addr_d;
    logic              need_mem_q, need_mem_d;
    logic [WAY_W-1:0]  victim_q, victim_d;
    logic [WAY_W-1:0]  rr_q [SETS];
    logic [WAY_W-1:0]  rr_next;

    logic [OFF_W-1:0]  pc_off;
    logic [SET_W-1:0]  pc_set, fill_set, wr_set;
    logic [TAG_W-1:0]  pc_tag, fill_tag;
    logic [WAY_W-1:0]  sel_way;

    logic [31:0]       way_word [WAYS];
    logic [WAYS-1:0]   way_match;
    logic              any_match;
    logic [31:0]       match_word;
    logic              fwd;

    logic              data_we, line_install, line_inv, flush_all;

    assign pc_off   = input_pc[2 +: OFF_W];
    assign pc_set   = input_pc[SET_LSB +: SET_W];
    assign pc_tag   = input_pc[TAG_LSB +: TAG_W];
    // The refill address never leaves its line, so its set/tag fields name the line being filled.
    assign fill_set = mem_addr_q[SET_LSB +: SET_W];
    assign fill_tag = mem_addr_q[TAG_LSB +: TAG_W];
    assign cnt_inc  = cnt_q + 1'b1;

    assign wr_set  = (state_q == ST_FILL) ? fill_set : pc_set;
    assign sel_way = (state_q == ST_FILL) ? victim_q : rr_q[pc_set];
    assign rr_next = (rr_q[fill_set] == WAY_W'(WAYS - 1)) ? '0 : rr_q[fill_set] + 1'b1;

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        icache_assoc_line_way #(
            .SETS       (SETS),
            .LINE_WORDS (LINE_WORDS),
            .TAG_W      (TAG_W)
        ) u_way (
            .clk_i      (clk_in),
            .rst_n_i    (rst_in),
            .rd_set_i   (pc_set),
            .rd_off_i   (pc_off),
            .rd_tag_i   (pc_tag),
            .rd_word_o  (way_word[w]),
            .rd_match_o (way_match[w]),
            .wr_en_i    (rdy_in && data_we && (sel_way == WAY_W'(w))),
            .wr_set_i   (wr_set),
            .wr_off_i   (cnt_q),
            .wr_word_i  (mem_ins),
            .tag_wr_i   (rdy_in && line_install && (sel_way == WAY_W'(w))),
            .tag_i      (fill_tag),
            .inv_i      (rdy_in && line_inv && (sel_way == WAY_W'(w))),
            .flush_i    (rdy_in && flush_all)
        );
    end

    always_comb begin
        any_match  = 1'b0;
        match_word = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (way_match[w]) begin
                any_match  = 1'b1;
                match_word = way_word[w];
            end
        end
    end

    // Words already written during FILL stay hidden behind the cleared valid bit; only the live beat forwards.
    assign fwd     = (state_q == ST_FILL) && mem_ins_ready && (mem_addr_q == input_pc);
    assign hit     = fetch_able && !flush && (any_match || fwd);
    assign hit_ins = fwd ? mem_ins : match_word;
    assign ins_pc  = input_pc;
    assign busy    = (state_q == ST_FILL);
    assign need_mem = need_mem_q;
    assign mem_addr = mem_addr_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        mem_addr_d   = mem_addr_q;
        need_mem_d   = need_mem_q;
        victim_d     = victim_q;
        data_we      = 1'b0;
        line_install = 1'b0;
        line_inv     = 1'b0;
        flush_all    = 1'b0;

        if (flush) begin
            flush_all  = 1'b1;
            state_d    = ST_IDLE;
            cnt_d      = '0;
            mem_addr_d = '0;
            need_mem_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (fetch_able && !any_match) begin
                        state_d    = ST_FILL;
                        cnt_d      = '0;
                        mem_addr_d = {input_pc[31:SET_LSB], {OFF_W{1'b0}}, 2'b00};
                        need_mem_d = 1'b1;
                        victim_d   = rr_q[pc_set];
                        line_inv   = 1'b1;
                    end
                end
                ST_FILL: begin
                    if (mem_ins_ready) begin
                        data_we    = 1'b1;
                        cnt_d      = cnt_inc;
                        mem_addr_d = {mem_addr_q[31:SET_LSB], cnt_inc, 2'b00};
                        if (cnt_q == OFF_W'(LINE_WORDS - 1)) begin
                            line_install = 1'b1;
                            need_mem_d   = 1'b0;
                            state_d      = ST_IDLE;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            mem_addr_q <= '0;
            need_mem_q <= 1'b0;
            victim_q   <= '0;
        end else if (rdy_in) begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mem_addr_q <= mem_addr_d;
            need_mem_q <= need_mem_d;
            victim_q   <= victim_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            for (int s = 0; s < SETS; s++) begin
                rr_q[s] <= '0;
            end
        end else if (rdy_in && line_install) begin
            rr_q[fill_set] <= rr_next;
        end
    end

endmodule
